// File: rtl/fft_stage_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fft_stage_ctrl
//  Description : Radix-2 DIT FFT stage sequencer. Walks LOG2N stages of N/2
//                butterflies, drives ping-pong RAM read/write addresses,
//                twiddle index and bank select. Write-back is the read side
//                delayed by the read + butterfly pipeline latency.
//  Revision    : 1.0  initial release
// ============================================================================
module fft_stage_ctrl #(
    parameter int   N          = 32,
    parameter int   RD_LATENCY = 1,
    parameter int   BF_LATENCY = 2,
    localparam int  LOG2N      = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [LOG2N-1:0] stage_o,
    output logic             bank_select_o,
    output logic             rd_valid_o,
    output logic [LOG2N-1:0] rd_address1_o,
    output logic [LOG2N-1:0] rd_address2_o,
    output logic [LOG2N-2:0] tw_address_o,
    output logic             wr_en_o,
    output logic [LOG2N-1:0] wr_address1_o,
    output logic [LOG2N-1:0] wr_address2_o
);

    localparam int L    = RD_LATENCY + BF_LATENCY;
    localparam int HALF = N / 2;
    localparam int KW   = LOG2N - 1;
    localparam int DW   = (L > 1) ? $clog2(L) : 1;
    localparam int PW   = 2 * LOG2N + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [LOG2N-1:0] stage_q, stage_d;
    logic [KW-1:0]    k_q, k_d;
    logic [DW-1:0]    dcnt_q, dcnt_d;

    logic             busy_q, done_q, bank_q, rd_valid_q;
    logic [LOG2N-1:0] rd_a1_q, rd_a2_q;
    logic [KW-1:0]    tw_q;

    logic [LOG2N-1:0] kx_w, h_w, msk_w, a1_w, a2_w, tsh_w;
    logic [KW-1:0]    tw_w;

    logic [PW-1:0]    pipe_q [L];

    // Next-state logic for the stage/butterfly walk
    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        k_d     = k_q;
        dcnt_d  = dcnt_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_ISSUE;
                    stage_d = '0;
                    k_d     = '0;
                end
            end
            S_ISSUE: begin
                if (k_q == KW'(HALF - 1)) begin
                    state_d = S_DRAIN;
                    dcnt_d  = '0;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (dcnt_q == DW'(L - 1)) begin
                    if (stage_q == LOG2N'(LOG2N - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ISSUE;
                        stage_d = stage_q + 1'b1;
                        k_d     = '0;
                    end
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                stage_d = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Butterfly operand and twiddle addresses for the upcoming (k, stage)
    always_comb begin
        kx_w  = LOG2N'(k_d);
        h_w   = LOG2N'(1) << stage_d;
        msk_w = h_w - 1'b1;
        a1_w  = ((kx_w >> stage_d) << (stage_d + 1'b1)) | (kx_w & msk_w);
        a2_w  = a1_w + h_w;
        tsh_w = LOG2N'(LOG2N - 1) - stage_d;
        tw_w  = KW'((kx_w & msk_w) << tsh_w);
    end

    // Control state and registered read-side outputs, aligned to the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            stage_q    <= '0;
            k_q        <= '0;
            dcnt_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bank_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_a1_q    <= '0;
            rd_a2_q    <= '0;
            tw_q       <= '0;
        end else begin
            state_q    <= state_d;
            stage_q    <= stage_d;
            k_q        <= k_d;
            dcnt_q     <= dcnt_d;
            busy_q     <= (state_d == S_ISSUE) || (state_d == S_DRAIN);
            done_q     <= (state_d == S_DONE);
            bank_q     <= stage_d[0];
            rd_valid_q <= (state_d == S_ISSUE);
            // Addresses hold their last value outside ISSUE
            if (state_d == S_ISSUE) begin
                rd_a1_q <= a1_w;
                rd_a2_q <= a2_w;
                tw_q    <= tw_w;
            end
        end
    end

    // Write-back delay line matching the read + butterfly latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < L; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= {rd_valid_q, rd_a1_q, rd_a2_q};
            for (int i = 1; i < L; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign stage_o       = stage_q;
    assign bank_select_o = bank_q;
    assign rd_valid_o    = rd_valid_q;
    assign rd_address1_o = rd_a1_q;
    assign rd_address2_o = rd_a2_q;
    assign tw_address_o  = tw_q;
    assign {wr_en_o, wr_address1_o, wr_address2_o} = pipe_q[L-1];

endmodule
`default_nettype wire

// File: tb/tb_fft_stage_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fft_stage_ctrl
//  Description : Self-checking bench for fft_stage_ctrl, N=8 and N=32 instances
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fft_stage_ctrl;

    localparam int LAT = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic start8, start32;
    int   sel;
    int   vec = 0;
    int   mis = 0;

    logic       b8, d8, bs8, rv8, we8;
    logic [2:0] st8, ra1_8, ra2_8, wa1_8, wa2_8;
    logic [1:0] tw8;

    logic       b32, d32, bs32, rv32, we32;
    logic [4:0] st32, ra1_32, ra2_32, wa1_32, wa2_32;
    logic [3:0] tw32;

    logic [31:0] o_busy, o_done, o_stage, o_bank, o_rv, o_a1, o_a2, o_tw, o_we, o_wa1, o_wa2;

    always #5 clk = ~clk;

    fft_stage_ctrl #(.N(8), .RD_LATENCY(1), .BF_LATENCY(2)) dut8 (
        .clk(clk), .rst_n(rst_n), .start_i(start8),
        .busy_o(b8), .done_o(d8), .stage_o(st8), .bank_select_o(bs8),
        .rd_valid_o(rv8), .rd_address1_o(ra1_8), .rd_address2_o(ra2_8),
        .tw_address_o(tw8), .wr_en_o(we8),
        .wr_address1_o(wa1_8), .wr_address2_o(wa2_8)
    );

    fft_stage_ctrl dut32 (
        .clk(clk), .rst_n(rst_n), .start_i(start32),
        .busy_o(b32), .done_o(d32), .stage_o(st32), .bank_select_o(bs32),
        .rd_valid_o(rv32), .rd_address1_o(ra1_32), .rd_address2_o(ra2_32),
        .tw_address_o(tw32), .wr_en_o(we32),
        .wr_address1_o(wa1_32), .wr_address2_o(wa2_32)
    );

    // Observe the selected instance through width-neutral views
    always_comb begin
        if (sel != 0) begin
            o_busy = 32'(b32);  o_done = 32'(d32);   o_stage = 32'(st32);  o_bank = 32'(bs32);
            o_rv   = 32'(rv32); o_a1   = 32'(ra1_32); o_a2   = 32'(ra2_32); o_tw   = 32'(tw32);
            o_we   = 32'(we32); o_wa1  = 32'(wa1_32); o_wa2  = 32'(wa2_32);
        end else begin
            o_busy = 32'(b8);   o_done = 32'(d8);    o_stage = 32'(st8);   o_bank = 32'(bs8);
            o_rv   = 32'(rv8);  o_a1   = 32'(ra1_8); o_a2    = 32'(ra2_8); o_tw   = 32'(tw8);
            o_we   = 32'(we8);  o_wa1  = 32'(wa1_8); o_wa2   = 32'(wa2_8);
        end
    end

    task automatic drive_start(input int which, input logic v);
        if (which != 0) start32 = v; else start8 = v;
    endtask

    // One full transform: reference timeline built from the textbook DIT
    // grouping (group g of size 2h, offset j), then checked cycle by cycle.
    // hold: start stays high through DONE; noise: random start while busy.
    task automatic run_transform(input int which, input int hold, input int noise);
        int n, lg, T, h, e_wr;
        int q_rv[$], q_a1[$], q_a2[$], q_tw[$], q_st[$];
        logic ns;
        n  = (which != 0) ? 32 : 8;
        lg = (which != 0) ? 5 : 3;
        T  = lg * (n / 2 + LAT);
        sel = which;
        for (int s = 0; s < lg; s++) begin
            h = 1 << s;
            for (int g = 0; g < n / (2 * h); g++) begin
                for (int j = 0; j < h; j++) begin
                    q_rv.push_back(1);
                    q_a1.push_back(g * 2 * h + j);
                    q_a2.push_back(g * 2 * h + j + h);
                    q_tw.push_back(j * (n / (2 * h)));
                    q_st.push_back(s);
                end
            end
            for (int d = 0; d < LAT; d++) begin
                q_rv.push_back(0);
                q_a1.push_back(q_a1[$]);
                q_a2.push_back(q_a2[$]);
                q_tw.push_back(q_tw[$]);
                q_st.push_back(s);
            end
        end
        @(negedge clk);
        drive_start(which, 1'b1);
        for (int c = 0; c <= T + 1; c++) begin
            @(negedge clk);
            vec++;
            if (o_busy !== 32'(c < T)) begin mis++; $display("FAIL busy n=%0d cyc=%0d got=%0h exp=%0h", n, c, o_busy, (c < T)); end
            if (o_done !== 32'(c == T)) begin mis++; $display("FAIL done n=%0d cyc=%0d got=%0h exp=%0h", n, c, o_done, (c == T)); end
            if (o_rv !== ((c < T) ? q_rv[c] : 0)) begin mis++; $display("FAIL rd_valid n=%0d cyc=%0d got=%0h", n, c, o_rv); end
            if (c < T) begin
                if (o_stage !== q_st[c]) begin mis++; $display("FAIL stage n=%0d cyc=%0d got=%0d exp=%0d", n, c, o_stage, q_st[c]); end
                if (o_bank !== (q_st[c] & 1)) begin mis++; $display("FAIL bank n=%0d cyc=%0d got=%0d exp=%0d", n, c, o_bank, q_st[c] & 1); end
                if (o_a1 !== q_a1[c] || o_a2 !== q_a2[c]) begin
                    mis++; $display("FAIL rd_addr n=%0d cyc=%0d got=(%0d,%0d) exp=(%0d,%0d)", n, c, o_a1, o_a2, q_a1[c], q_a2[c]);
                end
                if (o_tw !== q_tw[c]) begin mis++; $display("FAIL tw n=%0d cyc=%0d got=%0d exp=%0d", n, c, o_tw, q_tw[c]); end
            end
            e_wr = (c >= LAT && c - LAT < T) ? q_rv[c-LAT] : 0;
            if (o_we !== e_wr) begin mis++; $display("FAIL wr_en n=%0d cyc=%0d got=%0h exp=%0d", n, c, o_we, e_wr); end
            if (e_wr != 0 && (o_wa1 !== q_a1[c-LAT] || o_wa2 !== q_a2[c-LAT])) begin
                mis++; $display("FAIL wr_addr n=%0d cyc=%0d got=(%0d,%0d) exp=(%0d,%0d)", n, c, o_wa1, o_wa2, q_a1[c-LAT], q_a2[c-LAT]);
            end
            if (c == T && o_bank !== ((lg - 1) & 1)) begin mis++; $display("FAIL result_bank n=%0d got=%0d exp=%0d", n, o_bank, (lg - 1) & 1); end
            if (c == T + 1 && o_stage !== 0) begin mis++; $display("FAIL idle_stage n=%0d got=%0d exp=0", n, o_stage); end
            ns = 1'b0;
            if (c <= T) begin
                if (hold != 0) ns = 1'b1;
                else if (noise != 0) ns = 1'($urandom % 2);
            end
            drive_start(which, ns);
        end
    endtask

    task automatic test_reset();
        #3;
        for (int w = 0; w < 2; w++) begin
            sel = w;
            #1;
            vec++;
            if ((o_busy | o_done | o_stage | o_bank | o_rv | o_a1 | o_a2 | o_tw | o_we | o_wa1 | o_wa2) !== 0) begin
                mis++; $display("FAIL reset_outputs inst=%0d got=%0h exp=0", w, o_busy | o_rv | o_we | o_a1 | o_stage);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            vec++;
            if (b8 !== 1'b0 || b32 !== 1'b0) begin mis++; $display("FAIL idle_busy got=%b%b exp=00", b8, b32); end
        end
    endtask

    task automatic test_stage_sequence();
        run_transform(0, 0, 0);
    endtask

    task automatic test_start_held();
        run_transform(0, 1, 0);
    endtask

    task automatic test_back_to_back();
        repeat ($urandom_range(0, 3)) @(negedge clk);
        run_transform(0, 0, 1);
        run_transform(0, 0, 0);
    endtask

    task automatic test_reset_mid_issue();
        sel = 0;
        @(negedge clk);
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        vec++;
        if (o_rv !== 1) begin mis++; $display("FAIL pre_abort_rd_valid got=%0h exp=1", o_rv); end
        #2 rst_n = 1'b0;
        #1;
        vec++;
        if ((o_busy | o_done | o_stage | o_bank | o_rv | o_a1 | o_a2 | o_tw | o_we | o_wa1 | o_wa2) !== 0) begin
            mis++; $display("FAIL abort_outputs got=busy%0h rv%0h we%0h a1%0h exp=0", o_busy, o_rv, o_we, o_a1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            vec++;
            if ((o_busy | o_done | o_rv | o_we) !== 0) begin
                mis++; $display("FAIL post_abort_idle got=busy%0h done%0h rv%0h we%0h exp=0", o_busy, o_done, o_rv, o_we);
            end
        end
    endtask

    task automatic test_n32();
        run_transform(1, 0, 0);
        run_transform(1, 0, 1);
    endtask

    initial begin
        rst_n   = 1'b0;
        start8  = 1'b0;
        start32 = 1'b0;
        sel     = 0;
        test_reset();
        test_stage_sequence();
        test_start_held();
        test_back_to_back();
        test_reset_mid_issue();
        test_stage_sequence();
        test_n32();
        $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
        $finish;
    end

endmodule
`default_nettype wire
